rv_wb_arbiter: RTL and testbench

//  Owns the single register-file write port of the RV32 core.

---
 rtl/rv_wb_arbiter_pkg.sv | 14 +
 rtl/rv_wb_fifo.sv | 53 +++++
 rtl/rv_wb_arbiter.sv | 155 +++++++++++++++
 tb/tb_rv_wb_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_wb_arbiter_pkg.sv
// Shared types and constants for the RV32 register-file write-port arbiter.
package rv_wb_arbiter_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned REG_W = 5;

    localparam logic [REG_W-1:0] REG_X0 = 5'd0;

    typedef struct packed {
        logic [REG_W-1:0] rd;
        logic [XLEN-1:0]  data;
    } wb_req_t;

endpackage

// File: rtl/rv_wb_fifo.sv
// Strict FIFO for long-latency results that lost the write port.
// Pushes into a full FIFO and pops from an empty one are ignored.
module rv_wb_fifo
    import rv_wb_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter type T = wb_req_t,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  T                 data_i,
    output T                 data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    T                 mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q;
    logic [PTR_W-1:0] rd_q;
    logic [CNT_W-1:0] cnt_q;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;
    assign data_o  = mem_q[rd_q];
    assign count_o = cnt_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_ok) wr_q <= PTR_W'(wr_q + 1'b1);
            if (pop_ok)  rd_q <= PTR_W'(rd_q + 1'b1);
            cnt_q <= CNT_W'(cnt_q + CNT_W'(push_ok) - CNT_W'(pop_ok));
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_q] <= data_i;
    end

endmodule

// File: rtl/rv_wb_arbiter.sv
// Register-file write-port owner: WB stage always wins, LL results are
// buffered, tracked in a pending scoreboard, and starvation raises a stall.
module rv_wb_arbiter
    import rv_wb_arbiter_pkg::*;
#(
    parameter int unsigned LL_DEPTH     = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_wb_valid,
    input  logic [REG_W-1:0]  i_wb_rd,
    input  logic [XLEN-1:0]   i_wb_data,
    input  logic              i_ll_issue,
    input  logic [REG_W-1:0]  i_ll_issue_rd,
    input  logic              i_ll_valid,
    input  logic [REG_W-1:0]  i_ll_rd,
    input  logic [XLEN-1:0]   i_ll_data,
    output logic              o_ll_ready,
    output logic [XLEN-1:0]   o_pending,
    output logic              o_stall_req,
    output logic              o_rf_we,
    output logic [REG_W-1:0]  o_rf_rd,
    output logic [XLEN-1:0]   o_rf_data
);

    localparam int unsigned CNT_W = $clog2(LL_DEPTH + 1);
    localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

    wb_req_t            ll_req;
    wb_req_t            fifo_head;
    wb_req_t            ll_win_req;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    logic [CNT_W-1:0]   count_nxt;
    logic               push;
    logic               pop;
    logic               ll_acc;
    logic               wb_win;
    logic               ll_win;

    logic               rf_we_d,   rf_we_q;
    logic [REG_W-1:0]   rf_rd_d,   rf_rd_q;
    logic [XLEN-1:0]    rf_data_d, rf_data_q;
    logic [XLEN-1:0]    clr_mask;
    logic [XLEN-1:0]    set_mask;
    logic [XLEN-1:0]    pending_d, pending_q;
    logic [STV_W-1:0]   starve_d,  starve_q;
    logic               stall_d,   stall_q;

    assign ll_req     = '{rd: i_ll_rd, data: i_ll_data};
    assign ll_acc     = i_ll_valid & ~fifo_full;
    assign wb_win     = i_wb_valid & (i_wb_rd != REG_X0);
    assign o_ll_ready = ~fifo_full;

    rv_wb_fifo #(
        .DEPTH (LL_DEPTH),
        .T     (wb_req_t)
    ) u_fifo (
        .clk_i   (i_clk),
        .reset_i (i_reset),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (ll_req),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Port arbitration: WB, then buffer head, then LL bypass.
    always_comb begin
        push       = 1'b0;
        pop        = 1'b0;
        ll_win     = 1'b0;
        ll_win_req = ll_req;
        rf_we_d    = 1'b0;
        rf_rd_d    = rf_rd_q;
        rf_data_d  = rf_data_q;
        clr_mask   = '0;
        if (wb_win) begin
            rf_we_d   = 1'b1;
            rf_rd_d   = i_wb_rd;
            rf_data_d = i_wb_data;
            push      = ll_acc;
        end else if (!fifo_empty) begin
            pop        = 1'b1;
            push       = ll_acc;
            ll_win     = 1'b1;
            ll_win_req = fifo_head;
        end else if (ll_acc) begin
            ll_win = 1'b1;
        end
        // An LL result to x0 is consumed without touching the port.
        if (ll_win && (ll_win_req.rd != REG_X0)) begin
            rf_we_d              = 1'b1;
            rf_rd_d              = ll_win_req.rd;
            rf_data_d            = ll_win_req.data;
            clr_mask[ll_win_req.rd] = 1'b1;
        end
    end

    // Scoreboard, starvation counter and stall request; set beats clear.
    always_comb begin
        set_mask = '0;
        if (i_ll_issue && (i_ll_issue_rd != REG_X0)) set_mask[i_ll_issue_rd] = 1'b1;
        pending_d = (pending_q & ~clr_mask) | set_mask;

        starve_d = '0;
        if (!fifo_empty && wb_win) begin
            starve_d = (starve_q == STV_W'(STARVE_LIMIT)) ? starve_q : STV_W'(starve_q + 1'b1);
        end

        count_nxt = CNT_W'(fifo_count + CNT_W'(push) - CNT_W'(pop));
        stall_d   = (starve_d == STV_W'(STARVE_LIMIT)) || (count_nxt == CNT_W'(LL_DEPTH));
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rf_we_q   <= 1'b0;
            rf_rd_q   <= '0;
            rf_data_q <= '0;
            pending_q <= '0;
            starve_q  <= '0;
            stall_q   <= 1'b0;
        end else begin
            rf_we_q   <= rf_we_d;
            rf_rd_q   <= rf_rd_d;
            rf_data_q <= rf_data_d;
            pending_q <= pending_d;
            starve_q  <= starve_d;
            stall_q   <= stall_d;
        end
    end

    assign o_rf_we     = rf_we_q;
    assign o_rf_rd     = rf_rd_q;
    assign o_rf_data   = rf_data_q;
    assign o_pending   = pending_q;
    assign o_stall_req = stall_q;

    // Upstream protocol checks; behaviour is undefined when these fire.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            assert (!(i_ll_issue && (i_ll_issue_rd != REG_X0) && pending_q[i_ll_issue_rd]))
                else $error("ll issue to pending rd %0d", i_ll_issue_rd);
            assert (!(i_wb_valid && (i_wb_rd != REG_X0) && pending_q[i_wb_rd]))
                else $error("wb write to pending rd %0d", i_wb_rd);
            assert (!(i_ll_valid && (i_ll_rd != REG_X0) && !pending_q[i_ll_rd]))
                else $error("ll result for non-pending rd %0d", i_ll_rd);
        end
    end

endmodule

// File: tb/tb_rv_wb_arbiter.sv
// Directed bench for rv_wb_arbiter with a cycle-stamped RF write scoreboard.
module tb_rv_wb_arbiter;
    import rv_wb_arbiter_pkg::*;

    logic              clk = 1'b0;
    logic              i_reset;
    logic              i_wb_valid;
    logic [4:0]        i_wb_rd;
    logic [31:0]       i_wb_data;
    logic              i_ll_issue;
    logic [4:0]        i_ll_issue_rd;
    logic              i_ll_valid;
    logic [4:0]        i_ll_rd;
    logic [31:0]       i_ll_data;
    logic              o_ll_ready;
    logic [31:0]       o_pending;
    logic              o_stall_req;
    logic              o_rf_we;
    logic [4:0]        o_rf_rd;
    logic [31:0]       o_rf_data;

    typedef struct {
        int unsigned cyc;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned cyc    = 0;
    int unsigned checks = 0;
    int unsigned errors = 0;

    rv_wb_arbiter #(.LL_DEPTH(2), .STARVE_LIMIT(4)) dut (
        .i_clk         (clk),
        .i_reset       (i_reset),
        .i_wb_valid    (i_wb_valid),
        .i_wb_rd       (i_wb_rd),
        .i_wb_data     (i_wb_data),
        .i_ll_issue    (i_ll_issue),
        .i_ll_issue_rd (i_ll_issue_rd),
        .i_ll_valid    (i_ll_valid),
        .i_ll_rd       (i_ll_rd),
        .i_ll_data     (i_ll_data),
        .o_ll_ready    (o_ll_ready),
        .o_pending     (o_pending),
        .o_stall_req   (o_stall_req),
        .o_rf_we       (o_rf_we),
        .o_rf_rd       (o_rf_rd),
        .o_rf_data     (o_rf_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_wr(input int unsigned off, input logic [4:0] rd, input logic [31:0] d);
        exp_t e;
        e.cyc  = cyc + off;
        e.rd   = rd;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Advance one clock; every cycle either a scheduled RF write or no write.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
            e = exp_q.pop_front();
            chk("rf_we", 32'(o_rf_we), 32'd1);
            chk("rf_rd", 32'(o_rf_rd), 32'(e.rd));
            chk("rf_data", o_rf_data, e.data);
        end else begin
            chk("rf_idle", 32'(o_rf_we), 32'd0);
        end
    endtask

    task automatic issue(input logic [4:0] rd);
        i_ll_issue    = 1'b1;
        i_ll_issue_rd = rd;
        tick();
        i_ll_issue    = 1'b0;
    endtask

    initial begin
        i_reset = 1'b1;
        i_wb_valid = 1'b0; i_wb_rd = '0; i_wb_data = '0;
        i_ll_issue = 1'b0; i_ll_issue_rd = '0;
        i_ll_valid = 1'b0; i_ll_rd = '0; i_ll_data = '0;
        tick();
        tick();
        chk("rst_rf_rd", 32'(o_rf_rd), 32'd0);
        chk("rst_rf_data", o_rf_data, 32'd0);
        chk("rst_pending", o_pending, 32'd0);
        chk("rst_stall", 32'(o_stall_req), 32'd0);
        chk("rst_ready", 32'(o_ll_ready), 32'd1);
        i_reset = 1'b0;
        tick();

        // WB only, then hold of address/data on an idle cycle
        i_wb_valid = 1'b1; i_wb_rd = 5'd5; i_wb_data = 32'h0000_1234;
        expect_wr(1, 5'd5, 32'h0000_1234);
        tick();
        chk("t1_ready", 32'(o_ll_ready), 32'd1);
        i_wb_valid = 1'b0;
        tick();
        chk("t1_hold_rd", 32'(o_rf_rd), 32'd5);
        chk("t1_hold_data", o_rf_data, 32'h0000_1234);
        chk("t1_ready2", 32'(o_ll_ready), 32'd1);

        // LL bypass with scoreboard tracking
        i_ll_issue = 1'b1; i_ll_issue_rd = 5'd7;
        tick();
        i_ll_issue = 1'b0;
        chk("t2_pend_n1", o_pending, 32'h0000_0080);
        tick();
        chk("t2_pend_n2", o_pending, 32'h0000_0080);
        tick();
        chk("t2_pend_n3", o_pending, 32'h0000_0080);
        i_ll_valid = 1'b1; i_ll_rd = 5'd7; i_ll_data = 32'hDEAD_BEEF;
        expect_wr(1, 5'd7, 32'hDEAD_BEEF);
        tick();
        i_ll_valid = 1'b0;
        chk("t2_pend_n4", o_pending, 32'd0);

        // Collision: WB first, buffered LL next cycle
        issue(5'd9);
        i_wb_valid = 1'b1; i_wb_rd = 5'd3; i_wb_data = 32'h3333_0003;
        i_ll_valid = 1'b1; i_ll_rd = 5'd9; i_ll_data = 32'h9999_0009;
        expect_wr(1, 5'd3, 32'h3333_0003);
        expect_wr(2, 5'd9, 32'h9999_0009);
        tick();
        i_wb_valid = 1'b0; i_ll_valid = 1'b0;
        chk("t3_ready", 32'(o_ll_ready), 32'd1);
        chk("t3_pend_n1", o_pending, 32'h0000_0200);
        tick();
        chk("t3_pend_n2", o_pending, 32'd0);
        chk("t3_stall", 32'(o_stall_req), 32'd0);

        // Full buffer with a held third LL result
        issue(5'd10);
        issue(5'd11);
        issue(5'd12);
        i_wb_valid = 1'b1; i_wb_rd = 5'd20; i_wb_data = 32'hA000_0020;
        i_ll_valid = 1'b1; i_ll_rd = 5'd10; i_ll_data = 32'hB000_000A;
        expect_wr(1, 5'd20, 32'hA000_0020);
        tick();
        chk("t4_ready_n1", 32'(o_ll_ready), 32'd1);
        i_wb_rd = 5'd21; i_wb_data = 32'hA000_0021;
        i_ll_rd = 5'd11; i_ll_data = 32'hB000_000B;
        expect_wr(1, 5'd21, 32'hA000_0021);
        tick();
        chk("t4_ready_n2", 32'(o_ll_ready), 32'd0);
        chk("t4_stall_n2", 32'(o_stall_req), 32'd1);
        i_wb_rd = 5'd22; i_wb_data = 32'hA000_0022;
        i_ll_rd = 5'd12; i_ll_data = 32'hB000_000C;
        expect_wr(1, 5'd22, 32'hA000_0022);
        tick();
        chk("t4_ready_n3", 32'(o_ll_ready), 32'd0);
        i_wb_rd = 5'd23; i_wb_data = 32'hA000_0023;
        expect_wr(1, 5'd23, 32'hA000_0023);
        tick();
        chk("t4_ready_n4", 32'(o_ll_ready), 32'd0);
        i_wb_valid = 1'b0;
        expect_wr(1, 5'd10, 32'hB000_000A);
        tick();
        chk("t4_ready_n5", 32'(o_ll_ready), 32'd1);
        chk("t4_stall_n5", 32'(o_stall_req), 32'd0);
        chk("t4_pend_n5", o_pending, 32'h0000_1800);
        expect_wr(1, 5'd11, 32'hB000_000B);
        tick();
        i_ll_valid = 1'b0;
        expect_wr(1, 5'd12, 32'hB000_000C);
        tick();
        chk("t4_pend_end", o_pending, 32'd0);

        // Starvation: one buffered entry behind six WB writes
        issue(5'd13);
        for (int i = 0; i < 6; i++) begin
            i_wb_valid = 1'b1;
            i_wb_rd    = 5'(i + 1);
            i_wb_data  = 32'hC000_0000 + 32'(i);
            if (i == 0) begin
                i_ll_valid = 1'b1; i_ll_rd = 5'd13; i_ll_data = 32'hD000_000D;
            end
            expect_wr(1, 5'(i + 1), 32'hC000_0000 + 32'(i));
            tick();
            i_ll_valid = 1'b0;
            chk("t5_stall", 32'(o_stall_req), (i >= 4) ? 32'd1 : 32'd0);
        end
        i_wb_valid = 1'b0;
        expect_wr(1, 5'd13, 32'hD000_000D);
        tick();
        chk("t5_stall_drop", 32'(o_stall_req), 32'd0);
        chk("t5_pend_end", o_pending, 32'd0);

        // x0 writes are no-ops for the port
        i_wb_valid = 1'b1; i_wb_rd = 5'd0; i_wb_data = 32'h5555_5555;
        tick();
        i_wb_valid = 1'b0;
        chk("t6_x0_wb_we", 32'(o_rf_we), 32'd0);
        i_ll_valid = 1'b1; i_ll_rd = 5'd0; i_ll_data = 32'h6666_6666;
        chk("t6_x0_ll_ready", 32'(o_ll_ready), 32'd1);
        tick();
        i_ll_valid = 1'b0;
        chk("t6_x0_ll_we", 32'(o_rf_we), 32'd0);
        chk("t6_x0_pend", o_pending, 32'd0);

        // Reset with two buffered entries and pending bits
        issue(5'd14);
        issue(5'd15);
        issue(5'd16);
        i_wb_valid = 1'b1; i_wb_rd = 5'd2; i_wb_data = 32'hE000_0002;
        i_ll_valid = 1'b1; i_ll_rd = 5'd14; i_ll_data = 32'hF000_000E;
        expect_wr(1, 5'd2, 32'hE000_0002);
        tick();
        i_wb_rd = 5'd3; i_wb_data = 32'hE000_0003;
        i_ll_rd = 5'd15; i_ll_data = 32'hF000_000F;
        expect_wr(1, 5'd3, 32'hE000_0003);
        tick();
        chk("t6_full_ready", 32'(o_ll_ready), 32'd0);
        chk("t6_pend_pre", o_pending, 32'h0001_C000);
        i_reset = 1'b1; i_wb_valid = 1'b0; i_ll_valid = 1'b0;
        tick();
        chk("t6_rst_rd", 32'(o_rf_rd), 32'd0);
        chk("t6_rst_data", o_rf_data, 32'd0);
        chk("t6_rst_pend", o_pending, 32'd0);
        chk("t6_rst_stall", 32'(o_stall_req), 32'd0);
        chk("t6_rst_ready", 32'(o_ll_ready), 32'd1);
        i_reset = 1'b0;
        tick();
        tick();
        tick();
        chk("t6_post_pend", o_pending, 32'd0);
        chk("sb_drain", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
